// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default pattern-length and field-width parameters.
package seq_pattern_pkg;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with clear and a zero flag. Decrement saturates at
// zero so the count never wraps, whatever the width.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    localparam logic [W-1:0] C_ZERO = {W{1'b0}};
    localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    // Count register: clear beats load, load beats decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= C_ZERO;
        end else if (i_clr) begin
            r_count <= C_ZERO;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != C_ZERO)) begin
            r_count <= r_count - C_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == C_ZERO);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends pattern[len-1:0] MSB first, repeat+1
// times, with gap idle cycles between passes, then pulses done.
module seq_pattern_tx #(
    parameter int MAX_LEN = seq_pattern_pkg::MAX_LEN,
    parameter int CNT_W   = seq_pattern_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [CNT_W-1:0]   i_len,
    input  logic [CNT_W-1:0]   i_repeat,
    input  logic [CNT_W-1:0]   i_gap,
    input  logic               i_abort,
    output logic               o_out,
    output logic               o_out_valid,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done
);

    import seq_pattern_pkg::*;

    localparam logic [CNT_W-1:0]   C_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]     C_MAX_LEN = (CNT_W+1)'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] C_PAT_Z   = {MAX_LEN{1'b0}};

    state_e             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_gap;
    logic               r_out;
    logic               r_out_valid;
    logic               r_done;

    logic               w_len_ok;
    logic [CNT_W-1:0]   w_start_idx;
    logic [CNT_W-1:0]   w_next_idx;
    logic [CNT_W-1:0]   w_first_idx;
    logic [MAX_LEN-1:0] w_start_vec;
    logic [MAX_LEN-1:0] w_next_vec;
    logic [MAX_LEN-1:0] w_first_vec;
    logic               w_start_bit;
    logic               w_next_bit;
    logic               w_first_bit;
    logic               w_gap_nz;

    logic               w_clr;
    logic               w_bit_load;
    logic [CNT_W-1:0]   w_bit_load_val;
    logic               w_bit_dec;
    logic               w_pass_load;
    logic               w_pass_dec;
    logic               w_gap_load;
    logic               w_gap_dec;
    logic [CNT_W-1:0]   w_bit_cnt;
    logic [CNT_W-1:0]   w_pass_cnt;
    logic [CNT_W-1:0]   w_gap_cnt;
    logic               w_bit_zero;
    logic               w_pass_zero;
    logic               w_gap_zero;
    logic               w_unused_cnt;

    // Length check on the live inputs: lengths 1..MAX_LEN produce a transfer.
    assign w_len_ok = (i_len != C_ZERO) && ({1'b0, i_len} <= C_MAX_LEN);

    // Bit selection by shifting keeps the index width independent of MAX_LEN.
    assign w_start_idx = i_len - C_ONE;
    assign w_start_vec = i_pattern >> w_start_idx;
    assign w_start_bit = w_start_vec[0];
    assign w_next_idx  = w_bit_cnt - C_ONE;
    assign w_next_vec  = r_pattern >> w_next_idx;
    assign w_next_bit  = w_next_vec[0];
    assign w_first_idx = r_len - C_ONE;
    assign w_first_vec = r_pattern >> w_first_idx;
    assign w_first_bit = w_first_vec[0];
    assign w_gap_nz    = (r_gap != C_ZERO);

    // Pass and gap counts only matter through their zero flags.
    assign w_unused_cnt = ^{w_pass_cnt, w_gap_cnt};

    // Counter control: bit counter holds the index of the bit on the wire,
    // pass counter the passes still to come, gap counter the idle cycles left.
    always_comb begin
        w_clr          = 1'b0;
        w_bit_load     = 1'b0;
        w_bit_load_val = C_ZERO;
        w_bit_dec      = 1'b0;
        w_pass_load    = 1'b0;
        w_pass_dec     = 1'b0;
        w_gap_load     = 1'b0;
        w_gap_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && w_len_ok) begin
                    w_bit_load     = 1'b1;
                    w_bit_load_val = w_start_idx;
                    w_pass_load    = 1'b1;
                end else begin
                    w_clr = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (i_abort) begin
                    w_clr = 1'b1;
                end else if (!w_bit_zero) begin
                    w_bit_dec = 1'b1;
                end else if (!w_pass_zero) begin
                    w_pass_dec = 1'b1;
                    if (w_gap_nz) begin
                        w_gap_load = 1'b1;
                    end else begin
                        w_bit_load     = 1'b1;
                        w_bit_load_val = w_first_idx;
                    end
                end else begin
                    w_clr = 1'b0;
                end
            end
            ST_GAP: begin
                if (i_abort) begin
                    w_clr = 1'b1;
                end else if (w_gap_zero) begin
                    w_bit_load     = 1'b1;
                    w_bit_load_val = w_first_idx;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_clr = 1'b1;
            end
            default: begin
                w_clr = 1'b1;
            end
        endcase
    end

    down_counter #(.W(CNT_W)) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_bit_load),
        .i_load_val (w_bit_load_val),
        .i_dec      (w_bit_dec),
        .o_count    (w_bit_cnt),
        .o_zero     (w_bit_zero)
    );

    down_counter #(.W(CNT_W)) u_pass_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_pass_load),
        .i_load_val (i_repeat),
        .i_dec      (w_pass_dec),
        .o_count    (w_pass_cnt),
        .o_zero     (w_pass_zero)
    );

    down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_gap_load),
        .i_load_val (r_gap - C_ONE),
        .i_dec      (w_gap_dec),
        .o_count    (w_gap_cnt),
        .o_zero     (w_gap_zero)
    );

    // Main FSM with latched transfer fields and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pattern   <= C_PAT_Z;
            r_len       <= C_ZERO;
            r_gap       <= C_ZERO;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_pattern <= i_pattern;
                        r_len     <= i_len;
                        r_gap     <= i_gap;
                        if (w_len_ok) begin
                            r_state     <= ST_SHIFT;
                            r_out       <= w_start_bit;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out       <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end else begin
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (i_abort) begin
                        r_state     <= ST_IDLE;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b0;
                    end else if (!w_bit_zero) begin
                        r_out       <= w_next_bit;
                        r_out_valid <= 1'b1;
                    end else if (!w_pass_zero) begin
                        if (w_gap_nz) begin
                            r_state     <= ST_GAP;
                            r_out       <= 1'b0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out       <= w_first_bit;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_state     <= ST_DONE;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (i_abort) begin
                        r_state     <= ST_IDLE;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end else if (w_gap_zero) begin
                        r_state     <= ST_SHIFT;
                        r_out       <= w_first_bit;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_ready     = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_pattern;
    logic [3:0] i_len;
    logic [3:0] i_repeat;
    logic [3:0] i_gap;
    logic       i_abort;
    logic       o_out;
    logic       o_out_valid;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    seq_pattern_tx #(.MAX_LEN(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_pattern   (i_pattern),
        .i_len       (i_len),
        .i_repeat    (i_repeat),
        .i_gap       (i_gap),
        .i_abort     (i_abort),
        .o_out       (o_out),
        .o_out_valid (o_out_valid),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let one edge accept it, then scramble the fields.
    task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                            input logic [3:0] rep, input logic [3:0] gap);
        i_pattern = pat;
        i_len     = len;
        i_repeat  = rep;
        i_gap     = gap;
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
        i_pattern = ~pat;
        i_len     = 4'd2;
        i_repeat  = 4'd5;
        i_gap     = 4'd6;
    endtask

    task automatic test_reset();
        logic [3:0] exp_bits = 4'b1011;
        step();
        total++;
        if (o_out !== 1'b0 || o_out_valid !== 1'b0 || o_done !== 1'b0 ||
            o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out=%b valid=%b done=%b ready=%b busy=%b need 0 0 0 1 0",
                     o_out, o_out_valid, o_done, o_ready, o_busy);
        end
        rst_n = 1'b1;
        do_start(8'b0000_1011, 4'd4, 4'd0, 4'd0);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (o_out_valid !== 1'b1 || o_out !== exp_bits[3-c]) begin
                bad++;
                $display("FAIL first_start_bit%0d: out=%b valid=%b need out=%b valid=1",
                         c, o_out, o_out_valid, exp_bits[3-c]);
            end
            step();
        end
        total++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0 || o_out !== 1'b0 || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b valid=%b out=%b ready=%b need 1 0 0 0",
                     o_done, o_out_valid, o_out, o_ready);
        end
        step();
        total++;
        if (o_ready !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready: ready=%b done=%b busy=%b need 1 0 0",
                     o_ready, o_done, o_busy);
        end
    endtask

    task automatic test_repeat();
        logic [3:0] exp_bits = 4'b1011;
        do_start(8'b0000_1011, 4'd4, 4'd2, 4'd0);
        for (int c = 0; c < 12; c++) begin
            total++;
            if (o_out_valid !== 1'b1 || o_out !== exp_bits[3-(c%4)]) begin
                bad++;
                $display("FAIL repeat_bit%0d: out=%b valid=%b need out=%b valid=1",
                         c, o_out, o_out_valid, exp_bits[3-(c%4)]);
            end
            step();
        end
        total++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL repeat_done: done=%b valid=%b need 1 0", o_done, o_out_valid);
        end
        step();
    endtask

    task automatic test_gap();
        logic [3:0] exp_bits = 4'b1011;
        logic       ev;
        logic       eo;
        do_start(8'b0000_1011, 4'd4, 4'd1, 4'd3);
        for (int c = 0; c < 11; c++) begin
            if (c >= 4 && c <= 6) begin
                ev = 1'b0;
                eo = 1'b0;
            end else begin
                ev = 1'b1;
                eo = exp_bits[3-((c < 4) ? c : c - 7)];
            end
            total++;
            if (o_out_valid !== ev || o_out !== eo || o_done !== 1'b0) begin
                bad++;
                $display("FAIL gap_cycle%0d: out=%b valid=%b done=%b need out=%b valid=%b done=0",
                         c + 1, o_out, o_out_valid, o_done, eo, ev);
            end
            step();
        end
        total++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL gap_done: done=%b valid=%b need 1 0", o_done, o_out_valid);
        end
        step();
    endtask

    task automatic test_bad_len();
        logic [3:0] lens [2] = '{4'd0, 4'd9};
        for (int k = 0; k < 2; k++) begin
            do_start(8'hFF, lens[k], 4'd1, 4'd1);
            total++;
            if (o_done !== 1'b1 || o_out_valid !== 1'b0 || o_out !== 1'b0 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL badlen%0d_done: done=%b valid=%b out=%b busy=%b need 1 0 0 1",
                         lens[k], o_done, o_out_valid, o_out, o_busy);
            end
            step();
            total++;
            if (o_ready !== 1'b1 || o_done !== 1'b0 || o_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL badlen%0d_idle: ready=%b done=%b valid=%b need 1 0 0",
                         lens[k], o_ready, o_done, o_out_valid);
            end
        end
    endtask

    task automatic test_max_repeat();
        do_start(8'b0000_0001, 4'd1, 4'd15, 4'd0);
        for (int c = 0; c < 16; c++) begin
            total++;
            if (o_out_valid !== 1'b1 || o_out !== 1'b1) begin
                bad++;
                $display("FAIL maxrep_bit%0d: out=%b valid=%b need 1 1", c, o_out, o_out_valid);
            end
            step();
        end
        total++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL maxrep_done: done=%b valid=%b need 1 0", o_done, o_out_valid);
        end
        step();
    endtask

    task automatic test_abort();
        logic [3:0] exp_bits = 4'b1011;
        do_start(8'b1100_1010, 4'd8, 4'd0, 4'd0);
        for (int c = 0; c < 2; c++) begin
            total++;
            if (o_out_valid !== 1'b1 || o_out !== 1'b1) begin
                bad++;
                $display("FAIL abort_pre_bit%0d: out=%b valid=%b need 1 1", c, o_out, o_out_valid);
            end
            if (c == 1) i_abort = 1'b1;
            step();
        end
        total++;
        if (o_out_valid !== 1'b0 || o_out !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle: valid=%b out=%b done=%b ready=%b need 0 0 0 1",
                     o_out_valid, o_out, o_done, o_ready);
        end
        do_start(8'b0000_1011, 4'd4, 4'd0, 4'd0);
        i_abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (o_out_valid !== 1'b1 || o_out !== exp_bits[3-c]) begin
                bad++;
                $display("FAIL abort_restart_bit%0d: out=%b valid=%b need out=%b valid=1",
                         c, o_out, o_out_valid, exp_bits[3-c]);
            end
            step();
        end
        total++;
        if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart_done: done=%b need 1", o_done);
        end
        step();
    endtask

    task automatic test_busy_start();
        logic [3:0] exp_bits = 4'b1011;
        do_start(8'b0000_1011, 4'd4, 4'd0, 4'd0);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (o_out_valid !== 1'b1 || o_out !== exp_bits[3-c]) begin
                bad++;
                $display("FAIL busy_start_bit%0d: out=%b valid=%b need out=%b valid=1",
                         c, o_out, o_out_valid, exp_bits[3-c]);
            end
            if (c == 1) begin
                i_start   = 1'b1;
                i_pattern = 8'hF4;
                i_len     = 4'd4;
            end else begin
                i_start = 1'b0;
            end
            step();
        end
        total++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_done: done=%b valid=%b need 1 0", o_done, o_out_valid);
        end
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        total++;
        if (o_ready !== 1'b1 || o_out_valid !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: ready=%b valid=%b done=%b need 1 0 0",
                     o_ready, o_out_valid, o_done);
        end
    endtask

    task automatic test_reset_mid();
        do_start(8'hFF, 4'd8, 4'd1, 4'd0);
        step();
        total++;
        if (o_out_valid !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: valid=%b busy=%b need 1 1", o_out_valid, o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (o_out !== 1'b0 || o_out_valid !== 1'b0 || o_done !== 1'b0 ||
            o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: out=%b valid=%b done=%b ready=%b busy=%b need 0 0 0 1 0",
                     o_out, o_out_valid, o_done, o_ready, o_busy);
        end
        step();
        rst_n = 1'b1;
        do_start(8'b0000_0100, 4'd3, 4'd0, 4'd0);
        total++;
        if (o_out_valid !== 1'b1 || o_out !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_restart: out=%b valid=%b need 1 1", o_out, o_out_valid);
        end
        for (int c = 0; c < 4; c++) step();
        total++;
        if (o_ready !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_drain: ready=%b done=%b need 1 0", o_ready, o_done);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_pattern = 8'h00;
        i_len     = 4'd0;
        i_repeat  = 4'd0;
        i_gap     = 4'd0;
        test_reset();
        test_repeat();
        test_gap();
        test_bad_len();
        test_max_repeat();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
